// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the instruction/data memory port arbiter.
//   lc3b_word      : 16-bit machine word carried on every data/address bus
//   lc3b_mem_wmask : 2-bit byte-enable mask
//   lc3b_arb_state : arbiter FSM states
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_B = 2'd1,
    SERVE_A = 2'd2,
    RESPOND = 2'd3
  } lc3b_arb_state;

endpackage

// File: rtl/mem_port_arbiter_latch.sv
// -----------------------------------------------------------------------------
// arb_port_latch
//   Per-port result holder for mem_port_arbiter. It remembers that the port's
//   memory access finished and keeps the read data until the port is answered.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     capture   : the port's memory access finished this cycle
//     load      : the finished access was a read, so take rdata_in
//     clear     : the port's response goes out this cycle
//     rdata_in  : read data from physical memory
//     done      : access finished, response still owed
//     rdata     : last captured read data, held until the next capture
// -----------------------------------------------------------------------------
module arb_port_latch
  import mem_port_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  logic     load,
  input  logic     clear,
  input  lc3b_word rdata_in,
  output logic     done,
  output lc3b_word rdata
);

  // The done flag is set on capture and dropped when the response goes out.
  // Read data is only replaced by a read completion, so a write leaves the
  // previous value visible to the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      if (clear) begin
        done <= 1'b0;
      end else if (capture) begin
        done <= 1'b1;
      end
      if (load) begin
        rdata <= rdata_in;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported physical memory between the instruction-fetch
//   port (A) and the data port (B). Accesses are serialized, with B first when
//   both ask, and results are held until the port is answered.
//   Configuration macro: ARB_PAIRED_RESP_EN
//     defined   : a request pending on the other port is served before
//                 responding, and both responses pulse in the same cycle
//     undefined : every access is answered on its own, in separate cycles
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     a_read/a_write/a_wmask/
//       a_address/a_wdata           : port A request (level, held until a_resp)
//     a_resp, a_rdata               : port A done pulse and read data
//     b_*                           : port B, same as port A
//     pmem_read/pmem_write/pmem_wmask/
//       pmem_address/pmem_wdata     : downstream request
//     pmem_resp, pmem_rdata         : downstream done pulse and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,

  input  logic          a_read,
  input  logic          a_write,
  input  lc3b_mem_wmask a_wmask,
  input  lc3b_word      a_address,
  input  lc3b_word      a_wdata,
  output logic          a_resp,
  output lc3b_word      a_rdata,

  input  logic          b_read,
  input  logic          b_write,
  input  lc3b_mem_wmask b_wmask,
  input  lc3b_word      b_address,
  input  lc3b_word      b_wdata,
  output logic          b_resp,
  output lc3b_word      b_rdata,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_wmask,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  lc3b_arb_state state;

  logic a_req;
  logic b_req;
  logic a_done;
  logic b_done;
  logic a_capture;
  logic b_capture;
  logic respond;
  logic b_exit_to_a;
  logic a_exit_to_b;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  assign a_capture = (state == SERVE_A) & pmem_resp;
  assign b_capture = (state == SERVE_B) & pmem_resp;
  assign respond   = (state == RESPOND);

  // When pairing is on, finishing one port's access hands memory straight to
  // the other port if it is waiting and has not been served yet, so that both
  // answers can be released together.
`ifdef ARB_PAIRED_RESP_EN
  assign b_exit_to_a = a_req & ~a_done;
  assign a_exit_to_b = b_req & ~b_done;
`else
  assign b_exit_to_a = 1'b0;
  assign a_exit_to_b = 1'b0;
`endif

  // Arbitration FSM. B wins ties in IDLE. A SERVE state waits for the memory
  // to finish; a stray pmem_resp outside SERVE has no effect. RESPOND always
  // lasts exactly one cycle, and new requests are only looked at from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (b_req) begin
            state <= SERVE_B;
          end else if (a_req) begin
            state <= SERVE_A;
          end
        end
        SERVE_B: begin
          if (pmem_resp) begin
            state <= b_exit_to_a ? SERVE_A : RESPOND;
          end
        end
        SERVE_A: begin
          if (pmem_resp) begin
            state <= a_exit_to_b ? SERVE_B : RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The memory sees the served port's request directly, with no added
  // latency; everywhere else the downstream bus is parked at zero.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wmask   = '0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      SERVE_B: begin
        pmem_read    = b_read;
        pmem_write   = b_write;
        pmem_wmask   = b_wmask;
        pmem_address = b_address;
        pmem_wdata   = b_wdata;
      end
      SERVE_A: begin
        pmem_read    = a_read;
        pmem_write   = a_write;
        pmem_wmask   = a_wmask;
        pmem_address = a_address;
        pmem_wdata   = a_wdata;
      end
      default: begin
      end
    endcase
  end

  // Only ports whose access actually finished get a response pulse.
  assign a_resp = respond & a_done;
  assign b_resp = respond & b_done;

  arb_port_latch u_a_latch (
    .clk      (clk),
    .rst      (rst),
    .capture  (a_capture),
    .load     (a_capture & a_read),
    .clear    (respond),
    .rdata_in (pmem_rdata),
    .done     (a_done),
    .rdata    (a_rdata)
  );

  arb_port_latch u_b_latch (
    .clk      (clk),
    .rst      (rst),
    .capture  (b_capture),
    .load     (b_capture & b_read),
    .clear    (respond),
    .rdata_in (pmem_rdata),
    .done     (b_done),
    .rdata    (b_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A transaction-level model of the
//   arbiter (who owns memory, which results are owed) predicts every output
//   each cycle; directed scenarios add hand-computed literal expectations.
//   Honours ARB_PAIRED_RESP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_read, a_write, b_read, b_write;
  lc3b_mem_wmask a_wmask, b_wmask;
  lc3b_word      a_address, a_wdata, b_address, b_wdata;
  logic          a_resp, b_resp;
  lc3b_word      a_rdata, b_rdata;
  logic          pmem_read, pmem_write, pmem_resp;
  lc3b_mem_wmask pmem_wmask;
  lc3b_word      pmem_address, pmem_wdata, pmem_rdata;

  int compared   = 0;
  int mismatched = 0;

`ifdef ARB_PAIRED_RESP_EN
  localparam bit Paired = 1'b1;
`else
  localparam bit Paired = 1'b0;
`endif

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .a_read       (a_read),
    .a_write      (a_write),
    .a_wmask      (a_wmask),
    .a_address    (a_address),
    .a_wdata      (a_wdata),
    .a_resp       (a_resp),
    .a_rdata      (a_rdata),
    .b_read       (b_read),
    .b_write      (b_write),
    .b_wmask      (b_wmask),
    .b_address    (b_address),
    .b_wdata      (b_wdata),
    .b_resp       (b_resp),
    .b_rdata      (b_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wmask   (pmem_wmask),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string name, input logic [69:0] actual,
                             input logic [69:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model: owner is the port currently holding memory
  // (-1 none, 0 = A, 1 = B), owed[] marks finished accesses not yet answered,
  // answering means this cycle releases the owed responses.
  // ---------------------------------------------------------------------------
  int       m_owner     = -1;
  bit       m_owed[2]   = '{1'b0, 1'b0};
  bit       m_answering = 1'b0;
  lc3b_word m_rdata[2]  = '{16'h0, 16'h0};
  bit       model_valid = 1'b0;

  function automatic bit wants(input int port);
    return (port == 0) ? (a_read | a_write) : (b_read | b_write);
  endfunction

  initial begin
    int other;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner     = -1;
        m_owed      = '{1'b0, 1'b0};
        m_answering = 1'b0;
        m_rdata     = '{16'h0, 16'h0};
        model_valid = 1'b1;
      end else if (m_answering) begin
        m_answering = 1'b0;
        m_owed      = '{1'b0, 1'b0};
      end else if (m_owner < 0) begin
        if (wants(1)) m_owner = 1;
        else if (wants(0)) m_owner = 0;
      end else if (pmem_resp) begin
        m_owed[m_owner] = 1'b1;
        if ((m_owner == 0) ? a_read : b_read) m_rdata[m_owner] = pmem_rdata;
        other = 1 - m_owner;
        if (Paired && wants(other) && !m_owed[other]) begin
          m_owner = other;
        end else begin
          m_owner     = -1;
          m_answering = 1'b1;
        end
      end
    end
  end

  // Every cycle after reset: the DUT's full output vector against the model.
  initial begin
    logic [69:0] expv;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        expv = '0;
        if (m_owner == 0)
          expv[69:34] = {a_read, a_write, a_wmask, a_address, a_wdata};
        else if (m_owner == 1)
          expv[69:34] = {b_read, b_write, b_wmask, b_address, b_wdata};
        expv[33:0] = {m_answering & m_owed[0], m_answering & m_owed[1],
                      m_rdata[0], m_rdata[1]};
        checkOutput("cycle", {pmem_read, pmem_write, pmem_wmask, pmem_address,
                              pmem_wdata, a_resp, b_resp, a_rdata, b_rdata}, expv);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle agent: observes this cycle's outputs, plays the requesters
  // (drop the request once answered) and the memory (answer on the Nth
  // cycle of each access, data from a queue).
  // ---------------------------------------------------------------------------
  int       cyc = 0;
  int       a_resp_cnt, b_resp_cnt, a_resp_cyc, b_resp_cyc, presp_cyc;
  lc3b_word a_rd_seen, b_rd_seen;
  lc3b_word serve_addrs[$];
  lc3b_word rdq[$];
  bit       wr_seen;
  lc3b_word wr_addr, wr_data;
  logic [1:0] wr_mask;
  int       serve_cnt;
  int       resp_delay = 1;
  bit       auto_resp  = 1'b1;

  task automatic clearObs();
    a_resp_cnt = 0; b_resp_cnt = 0; a_resp_cyc = 0; b_resp_cyc = 0; presp_cyc = 0;
    serve_addrs.delete();
    rdq.delete();
    wr_seen = 1'b0;
    serve_cnt = 0;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    #2;
    cyc++;
    if (a_resp) begin
      a_resp_cnt++; a_resp_cyc = cyc; a_rd_seen = a_rdata;
      a_read = 1'b0; a_write = 1'b0;
    end
    if (b_resp) begin
      b_resp_cnt++; b_resp_cyc = cyc; b_rd_seen = b_rdata;
      b_read = 1'b0; b_write = 1'b0;
    end
    if (pmem_write && !wr_seen) begin
      wr_seen = 1'b1; wr_addr = pmem_address; wr_data = pmem_wdata; wr_mask = pmem_wmask;
    end
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      serve_cnt = 0;
    end
    if (pmem_read | pmem_write) begin
      serve_cnt++;
      if (serve_cnt == 1) serve_addrs.push_back(pmem_address);
      if (auto_resp && serve_cnt == resp_delay) begin
        pmem_resp  = 1'b1;
        pmem_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'h0000;
        presp_cyc  = cyc;
      end
    end
  endtask

  // Runs until the wanted number of responses arrived, bounded by a budget.
  task automatic runUntil(input int want_a, input int want_b);
    int n = 0;
    while ((a_resp_cnt < want_a || b_resp_cnt < want_b) && n < 40) begin
      applyStimulus();
      n++;
    end
    if (a_resp_cnt < want_a || b_resp_cnt < want_b)
      checkOutput("resp_timeout", 70'(a_resp_cnt * 16 + b_resp_cnt), 70'(want_a * 16 + want_b));
    applyStimulus();
    applyStimulus();
  endtask

  initial begin
    lc3b_word second;
    int n;
    bit b_sent;
    rst = 1'b1;
    a_read = 0; a_write = 0; a_wmask = 0; a_address = 0; a_wdata = 0;
    b_read = 0; b_write = 0; b_wmask = 0; b_address = 0; b_wdata = 0;
    pmem_resp = 0; pmem_rdata = 0;
    clearObs();
    repeat (3) applyStimulus();
    checkOutput("reset_outputs",
                70'({a_resp, b_resp, pmem_read, pmem_write, a_rdata, b_rdata}), 70'h0);
    rst = 1'b0;
    applyStimulus();

    // B read alone, memory answers on the second access cycle.
    $display("[TB] B read only");
    clearObs(); resp_delay = 2; rdq.push_back(16'hBEEF);
    b_read = 1'b1; b_address = 16'h1234;
    runUntil(0, 1);
    checkOutput("t1_b_rdata",   70'(b_rd_seen), 70'h0BEEF);
    checkOutput("t1_a_resp",    70'(a_resp_cnt), 70'd0);
    checkOutput("t1_latency",   70'(b_resp_cyc - presp_cyc), 70'd1);
    checkOutput("t1_addr",      70'(serve_addrs[0]), 70'h1234);

    // A and B reads together: B goes to memory first.
    $display("[TB] dual read");
    clearObs(); resp_delay = 1; rdq.push_back(16'h1111); rdq.push_back(16'h2222);
    a_read = 1'b1; a_address = 16'h0A00;
    b_read = 1'b1; b_address = 16'h0B00;
    runUntil(1, 1);
    checkOutput("t2_first_addr", 70'(serve_addrs[0]), 70'h0B00);
    checkOutput("t2_n_serves",   70'(serve_addrs.size()), 70'd2);
    checkOutput("t2_b_rdata",    70'(b_rd_seen), 70'h1111);
    checkOutput("t2_a_rdata",    70'(a_rd_seen), 70'h2222);
`ifdef ARB_PAIRED_RESP_EN
    checkOutput("t2_same_cycle", 70'(a_resp_cyc - b_resp_cyc), 70'd0);
`else
    checkOutput("t2_b_before_a", 70'(a_resp_cyc > b_resp_cyc), 70'd1);
`endif

    // B write leaves the held read data alone.
    $display("[TB] B write");
    clearObs(); resp_delay = 1; rdq.push_back(16'hDEAD);
    b_write = 1'b1; b_address = 16'h0040; b_wdata = 16'h00FF; b_wmask = 2'b01;
    runUntil(0, 1);
    b_wmask = 2'b00; b_wdata = 16'h0000;
    checkOutput("t3_wr_seen",  70'(wr_seen), 70'd1);
    checkOutput("t3_wr_bus",   70'({wr_addr, wr_data, wr_mask}), 70'({16'h0040, 16'h00FF, 2'b01}));
    checkOutput("t3_b_rdata",  70'(b_rd_seen), 70'h1111);
    checkOutput("t3_b_resp",   70'(b_resp_cnt), 70'd1);
    checkOutput("t3_a_rdata",  70'(a_rdata), 70'h2222);

    // A alone, then B shows up while A is being served.
    $display("[TB] late B request");
    clearObs(); resp_delay = 2; rdq.push_back(16'h3333); rdq.push_back(16'h4444);
    a_read = 1'b1; a_address = 16'h0AAA;
    b_sent = 1'b0; n = 0;
    while ((a_resp_cnt < 1 || b_resp_cnt < 1) && n < 40) begin
      applyStimulus();
      n++;
      if (serve_addrs.size() > 0 && !b_sent) begin
        b_read = 1'b1; b_address = 16'h0BBB; b_sent = 1'b1;
      end
    end
    applyStimulus();
    second = (serve_addrs.size() > 1) ? serve_addrs[1] : 16'h0000;
    checkOutput("t4_serve_b", 70'(second), 70'h0BBB);
    checkOutput("t4_a_rdata", 70'(a_rd_seen), 70'h3333);
    checkOutput("t4_b_rdata", 70'(b_rd_seen), 70'h4444);
`ifdef ARB_PAIRED_RESP_EN
    checkOutput("t4_same_cycle", 70'(a_resp_cyc - b_resp_cyc), 70'd0);
`else
    checkOutput("t4_a_before_b", 70'(b_resp_cyc > a_resp_cyc), 70'd1);
`endif

    // Reset in the middle of a B access, then a stray memory answer.
    $display("[TB] reset mid access");
    clearObs(); auto_resp = 1'b0;
    b_read = 1'b1; b_address = 16'h0C00;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("t5_pmem_read", 70'(pmem_read), 70'd0);
    checkOutput("t5_rdata",     70'({a_rdata, b_rdata}), 70'h0);
    rst = 1'b0; b_read = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = 16'h5A5A;
    repeat (3) applyStimulus();
    checkOutput("t5_stray_rdata", 70'({a_rdata, b_rdata}), 70'h0);
    checkOutput("t5_no_resp",     70'(a_resp_cnt + b_resp_cnt), 70'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
